dtcm_arb: RTL

DTCM port arbiter that shares the single DTCM command/response interface between two requesters: the LSU (`lsu_ctrl` DTCM side) and an external/system-bus slave port (`ext`, used for debug or DMA access). It selects one command per cycle using round-robin, holds the grant while a command is stalled, and records the requester ID of every accepted command in an in-order outstanding queue. Each DTCM response is routed back to the requester that issued it. It sits between `lsu_ctrl` and the DTCM wrapper.

---
 rtl/dtcm_arb_pkg.sv | 19 +
 rtl/dtcm_arb_idq.sv | 46 ++++
 rtl/dtcm_arb.sv | 124 ++++++++++++
 3 files changed

// File: rtl/dtcm_arb_pkg.sv
// Shared widths and requester IDs for the DTCM port arbiter.
// Two requesters share one DTCM port; the ID of each accepted command is queued for response routing.
package dtcm_arb_pkg;

  localparam int XLEN            = 32;
  localparam int DTCM_ADDR_WIDTH = 16;
  localparam int DTCM_OUTS_DEPTH = 2;
  localparam int DTCM_PTR_W      = (DTCM_OUTS_DEPTH > 2) ? 2 : 1;

  typedef enum logic {
    REQ_LSU = 1'b0,
    REQ_EXT = 1'b1
  } req_id_e;

  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ_LSU) ? REQ_EXT : REQ_LSU;
  endfunction

endpackage

// File: rtl/dtcm_arb_idq.sv
// In-order queue of 1-bit requester IDs for outstanding DTCM commands.
// Push and pop may happen in the same cycle at any fill level, including when the queue is full.
module dtcm_arb_idq #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             push_id,
  input  logic             pop,
  output logic             head_id,
  output logic [PTR_W:0]   count
);

  logic [DEPTH-1:0] ids;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // DEPTH may be 1, so wrap explicitly rather than relying on pointer overflow.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)
        count <= count + (PTR_W+1)'(1);
      else if (!push && pop)
        count <= count - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) ids[wr_ptr] <= push_id;
  end

  assign head_id = ids[rd_ptr];

endmodule

// File: rtl/dtcm_arb.sv
// Round-robin arbiter sharing the DTCM port between the LSU and the external slave port.
// Command and response paths are combinational; the grant is held while a command stalls.
module dtcm_arb
  import dtcm_arb_pkg::*;
#(
  parameter int OUTS_DEPTH = DTCM_OUTS_DEPTH,
  parameter int PTR_W      = DTCM_PTR_W
) (
  input  logic                       clk,
  input  logic                       rst_n,

  input  logic                       lsu_cmd_valid,
  output logic                       lsu_cmd_ready,
  input  logic                       lsu_cmd_read,
  input  logic [DTCM_ADDR_WIDTH-1:0] lsu_cmd_addr,
  input  logic [XLEN-1:0]            lsu_cmd_wdata,
  input  logic [XLEN/8-1:0]          lsu_cmd_wmask,
  output logic                       lsu_rsp_valid,
  input  logic                       lsu_rsp_ready,
  output logic [XLEN-1:0]            lsu_rsp_rdata,

  input  logic                       ext_cmd_valid,
  output logic                       ext_cmd_ready,
  input  logic                       ext_cmd_read,
  input  logic [DTCM_ADDR_WIDTH-1:0] ext_cmd_addr,
  input  logic [XLEN-1:0]            ext_cmd_wdata,
  input  logic [XLEN/8-1:0]          ext_cmd_wmask,
  output logic                       ext_rsp_valid,
  input  logic                       ext_rsp_ready,
  output logic [XLEN-1:0]            ext_rsp_rdata,

  output logic                       dtcm_cmd_valid,
  input  logic                       dtcm_cmd_ready,
  output logic                       dtcm_cmd_read,
  output logic [DTCM_ADDR_WIDTH-1:0] dtcm_cmd_addr,
  output logic [XLEN-1:0]            dtcm_cmd_wdata,
  output logic [XLEN/8-1:0]          dtcm_cmd_wmask,
  input  logic                       dtcm_rsp_valid,
  output logic                       dtcm_rsp_ready,
  input  logic [XLEN-1:0]            dtcm_rsp_rdata
);

  req_id_e        last_gnt;
  req_id_e        lock_id;
  req_id_e        gnt_id;
  logic           lock;
  logic           gnt_any;
  logic           gnt_valid;
  logic           gnt_ext;
  logic           q_avail;
  logic           q_busy;
  logic           push;
  logic           pop;
  logic           head_ext;
  logic [PTR_W:0] count;

  always_comb begin
    gnt_any = 1'b1;
    gnt_id  = REQ_LSU;
    if (lock)
      gnt_id = lock_id;
    else if (lsu_cmd_valid && ext_cmd_valid)
      gnt_id = other_req(last_gnt);
    else if (lsu_cmd_valid)
      gnt_id = REQ_LSU;
    else if (ext_cmd_valid)
      gnt_id = REQ_EXT;
    else
      gnt_any = 1'b0;
  end

  assign gnt_ext   = (gnt_id == REQ_EXT);
  assign gnt_valid = gnt_any & (gnt_ext ? ext_cmd_valid : lsu_cmd_valid);

  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign q_busy         = (count != '0);
  assign dtcm_rsp_ready = q_busy & (head_ext ? ext_rsp_ready : lsu_rsp_ready);
  assign pop            = dtcm_rsp_valid & dtcm_rsp_ready;
  assign q_avail        = (count < (PTR_W+1)'(OUTS_DEPTH)) | pop;

  assign dtcm_cmd_valid = gnt_valid & q_avail;
  assign push           = dtcm_cmd_valid & dtcm_cmd_ready;
  assign lsu_cmd_ready  = gnt_any & ~gnt_ext & dtcm_cmd_ready & q_avail;
  assign ext_cmd_ready  = gnt_any &  gnt_ext & dtcm_cmd_ready & q_avail;

  assign dtcm_cmd_read  = gnt_ext ? ext_cmd_read  : lsu_cmd_read;
  assign dtcm_cmd_addr  = gnt_ext ? ext_cmd_addr  : lsu_cmd_addr;
  assign dtcm_cmd_wdata = gnt_ext ? ext_cmd_wdata : lsu_cmd_wdata;
  assign dtcm_cmd_wmask = gnt_ext ? ext_cmd_wmask : lsu_cmd_wmask;

  assign lsu_rsp_valid  = dtcm_rsp_valid & q_busy & ~head_ext;
  assign ext_rsp_valid  = dtcm_rsp_valid & q_busy &  head_ext;
  assign lsu_rsp_rdata  = dtcm_rsp_rdata;
  assign ext_rsp_rdata  = dtcm_rsp_rdata;

  // last_gnt resets to ext so the LSU wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= REQ_EXT;
      lock     <= 1'b0;
      lock_id  <= REQ_LSU;
    end else if (push) begin
      last_gnt <= gnt_id;
      lock     <= 1'b0;
    end else if (dtcm_cmd_valid) begin
      lock     <= 1'b1;
      lock_id  <= gnt_id;
    end
  end

  dtcm_arb_idq #(
    .DEPTH (OUTS_DEPTH),
    .PTR_W (PTR_W)
  ) u_idq (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .push_id (gnt_ext),
    .pop     (pop),
    .head_id (head_ext),
    .count   (count)
  );

endmodule
